// File: rtl/tgif_round_ctrl.sv
// Round sequencer for the 4-rounds-per-cycle permutation, plus the round-constant
// generator it steers through const_init (x^7+x+1 LFSR, four constants per clock).

module tgif_round_const (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            init_i,
  output logic [3:0][6:0] c_o
);
  logic [6:0] lfsr_q, lfsr_d;

  function automatic logic [6:0] mul_x(input logic [6:0] a);
    return {a[5:0], 1'b0} ^ {5'b0, a[6], a[6]};
  endfunction

  // c_o[i] = alpha^i * lfsr_q; the register advances by alpha^4 each clock
  always_comb begin
    logic [6:0] t;
    t = lfsr_q;
    for (int i = 0; i < 4; i++) begin
      c_o[i] = t;
      t      = mul_x(t);
    end
    lfsr_d = t;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || init_i) lfsr_q <= 7'h01;
    else                 lfsr_q <= lfsr_d;
  end
endmodule

module tgif_round_ctrl #(
  parameter int NUM_STEPS = 16,
  parameter int STEP_W    = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              done_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              perm_load_o,
  output logic              perm_en_o,
  output logic              const_init_o,
  output logic [STEP_W-1:0] step_o,
  output logic              last_step_o
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [STEP_W-1:0] LAST = STEP_W'(NUM_STEPS - 1);

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;

  // step only advances inside RUN, so it reads 0 in every other state
  always_comb begin
    state_d = state_q;
    step_d  = '0;
    case (state_q)
      S_IDLE: if (start_i) state_d = S_LOAD;
      S_LOAD: state_d = abort_i ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort_i)             state_d = S_IDLE;
        else if (step_q == LAST) state_d = S_DONE;
        else                     step_d  = step_q + STEP_W'(1);
      end
      S_DONE: if (done_ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
    end
  end

  assign busy_o       = (state_q == S_LOAD) || (state_q == S_RUN);
  assign done_o       = (state_q == S_DONE);
  assign perm_load_o  = (state_q == S_LOAD);
  assign perm_en_o    = (state_q == S_RUN);
  assign const_init_o = (state_q != S_RUN);
  assign step_o       = step_q;
  assign last_step_o  = (state_q == S_RUN) && (step_q == LAST);
endmodule

// File: tb/tb_tgif_round_ctrl.sv
// Scoreboard bench: stimulus queues expected per-cycle outputs, monitors pop them.
module tb_tgif_round_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst, start_a, abort_a, ack_a, start_b, abort_b, ack_b;
  logic busy_a, done_a, load_a, en_a, cinit_a, last_a;
  logic busy_b, done_b, load_b, en_b, cinit_b, last_b;
  logic [4:0] step_a, step_b;
  logic [3:0][6:0] c_a;

  tgif_round_ctrl #(.NUM_STEPS(16), .STEP_W(5)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .abort_i(abort_a), .done_ack_i(ack_a),
    .busy_o(busy_a), .done_o(done_a), .perm_load_o(load_a), .perm_en_o(en_a),
    .const_init_o(cinit_a), .step_o(step_a), .last_step_o(last_a));

  tgif_round_ctrl #(.NUM_STEPS(1), .STEP_W(5)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .abort_i(abort_b), .done_ack_i(ack_b),
    .busy_o(busy_b), .done_o(done_b), .perm_load_o(load_b), .perm_en_o(en_b),
    .const_init_o(cinit_b), .step_o(step_b), .last_step_o(last_b));

  tgif_round_const u_const (.clk_i(clk), .rst_i(rst), .init_i(cinit_a), .c_o(c_a));

  typedef struct {
    string      nm;
    int         cyc;
    logic       busy, done, load, en, cinit, last;
    logic [4:0] step;
    bit         chk_c;
    logic [6:0] c0, c1;
  } exp_t;

  exp_t qa[$], qb[$];
  int errs = 0, checks = 0;

  // c0 = alpha^(4k), c1 = alpha^(4k+1) for steps 0..4, worked by hand
  logic [6:0] C0 [5] = '{7'h01, 7'h10, 7'h06, 7'h60, 7'h14};
  logic [6:0] C1 [5] = '{7'h02, 7'h20, 7'h0C, 7'h43, 7'h28};
  logic [10:0] idle_exp = 11'b00001_0_00000;

  function automatic void push(input bit b, input exp_t e);
    if (b) qb.push_back(e);
    else   qa.push_back(e);
  endfunction

  // start seen high at cycle s: LOAD s+1, RUN s+2.., DONE s+2+n for hold cycles
  task automatic exp_run(input bit b, input string nm, input int s, input int n,
                         input int runs, input int hold);
    exp_t e;
    e.nm = {nm, "_load"}; e.cyc = s + 1; e.busy = 1; e.done = 0; e.load = 1; e.en = 0;
    e.cinit = 1; e.last = 0; e.step = 0; e.chk_c = 0; e.c0 = 0; e.c1 = 0;
    push(b, e);
    for (int k = 0; k < runs; k++) begin
      e.nm = {nm, "_run"}; e.cyc = s + 2 + k; e.load = 0; e.en = 1; e.cinit = 0;
      e.step = 5'(k); e.last = (k == n - 1); e.chk_c = (!b && k < 5);
      if (k < 5) begin e.c0 = C0[k]; e.c1 = C1[k]; end
      push(b, e);
    end
    for (int j = 0; j < hold; j++) begin
      e.nm = {nm, "_done"}; e.cyc = s + 2 + n + j; e.busy = 0; e.done = 1; e.load = 0;
      e.en = 0; e.cinit = 1; e.last = 0; e.step = 0; e.chk_c = 0;
      push(b, e);
    end
  endtask

  task automatic mon(input bit b, input logic busy, done, load, en, cinit, last,
                     input logic [4:0] step, input logic [6:0] c0, c1);
    exp_t e;
    checks++;
    if ((b ? qb.size() : qa.size()) == 0) begin
      errs++;
      $display("FAIL unexpected_output dut=%0d cyc=%0d load=%b en=%b done=%b", b, cyc, load, en, done);
    end else begin
      e = b ? qb.pop_front() : qa.pop_front();
      if (cyc != e.cyc || busy !== e.busy || done !== e.done || load !== e.load ||
          en !== e.en || cinit !== e.cinit || last !== e.last || step !== e.step ||
          (e.chk_c && (c0 !== e.c0 || c1 !== e.c1)))
      begin
        errs++;
        $display("FAIL %s dut=%0d got cyc=%0d busy=%b done=%b load=%b en=%b cinit=%b last=%b step=%0d c0=%h c1=%h want cyc=%0d busy=%b done=%b load=%b en=%b cinit=%b last=%b step=%0d c0=%h c1=%h",
                 e.nm, b, cyc, busy, done, load, en, cinit, last, step, c0, c1,
                 e.cyc, e.busy, e.done, e.load, e.en, e.cinit, e.last, e.step, e.c0, e.c1);
      end
    end
  endtask

  always @(negedge clk)
    if (load_a === 1'b1 || en_a === 1'b1 || done_a === 1'b1)
      mon(0, busy_a, done_a, load_a, en_a, cinit_a, last_a, step_a, c_a[0], c_a[1]);

  always @(negedge clk)
    if (load_b === 1'b1 || en_b === 1'b1 || done_b === 1'b1)
      mon(1, busy_b, done_b, load_b, en_b, cinit_b, last_b, step_b, 7'h00, 7'h00);

  task automatic chk_idle(input bit b, input string nm);
    logic [10:0] act;
    act = b ? {busy_b, done_b, load_b, en_b, cinit_b, last_b, step_b}
            : {busy_a, done_a, load_a, en_a, cinit_a, last_a, step_a};
    checks++;
    if (act !== idle_exp) begin
      errs++;
      $display("FAIL %s dut=%0d busy/done/load/en/cinit/last/step got %b want %b", nm, b, act, idle_exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    rst = 1; start_a = 0; abort_a = 0; ack_a = 0; start_b = 0; abort_b = 0; ack_b = 0;
    repeat (2) @(negedge clk);
    chk_idle(0, "reset_a");
    chk_idle(1, "reset_b");
    rst = 0;
    @(negedge clk);

    // plain run, done held 3 cycles; ack/abort in IDLE ignored beforehand
    ack_a = 1; abort_a = 1;
    @(negedge clk);
    ack_a = 0; abort_a = 0;
    chk_idle(0, "idle_ignores_ack_abort");
    s = cyc; start_a = 1; exp_run(0, "run1", s, 16, 16, 3);
    @(negedge clk); start_a = 0;
    wait_cyc(s + 20); ack_a = 1;
    @(negedge clk); ack_a = 0;
    chk_idle(0, "run1_after_ack");

    // synchronous reset mid-RUN at step 5
    @(negedge clk);
    s = cyc; start_a = 1; exp_run(0, "rst_mid", s, 16, 6, 0);
    @(negedge clk); start_a = 0;
    wait_cyc(s + 7); rst = 1;
    @(negedge clk); rst = 0;
    chk_idle(0, "rst_mid_idle");

    // abort in RUN at step 3, then quiet period (no done may appear)
    @(negedge clk);
    s = cyc; start_a = 1; exp_run(0, "abort_run", s, 16, 4, 0);
    @(negedge clk); start_a = 0;
    wait_cyc(s + 5); abort_a = 1;
    @(negedge clk); abort_a = 0;
    chk_idle(0, "abort_run_idle");
    repeat (20) @(negedge clk);

    // abort in LOAD
    s = cyc; start_a = 1; exp_run(0, "abort_load", s, 16, 0, 0);
    @(negedge clk); start_a = 0; abort_a = 1;
    @(negedge clk); abort_a = 0;
    chk_idle(0, "abort_load_idle");

    // clean restart; abort in DONE ignored
    @(negedge clk);
    s = cyc; start_a = 1; exp_run(0, "restart", s, 16, 16, 2);
    @(negedge clk); start_a = 0;
    wait_cyc(s + 18); abort_a = 1;
    @(negedge clk); abort_a = 0; ack_a = 1;
    @(negedge clk); ack_a = 0;
    chk_idle(0, "restart_after_ack");

    // start held through the whole run and through DONE with ack
    s = cyc; start_a = 1; exp_run(0, "held", s, 16, 16, 2);
    wait_cyc(s + 19); ack_a = 1;
    @(negedge clk); ack_a = 0; start_a = 0;
    chk_idle(0, "held_back_idle");
    repeat (3) @(negedge clk);
    chk_idle(0, "held_no_rerun");
    s = cyc; start_a = 1; exp_run(0, "second", s, 16, 16, 1);
    @(negedge clk); start_a = 0;
    wait_cyc(s + 18); ack_a = 1;
    @(negedge clk); ack_a = 0;
    chk_idle(0, "second_after_ack");

    // NUM_STEPS=1 instance
    s = cyc; start_b = 1; exp_run(1, "one_step", s, 1, 1, 2);
    @(negedge clk); start_b = 0;
    wait_cyc(s + 4); ack_b = 1;
    @(negedge clk); ack_b = 0;
    chk_idle(1, "one_step_after_ack");

    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errs++;
      $display("FAIL missing_outputs pending_a=%0d pending_b=%0d want 0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
